// File: rtl/serial2tcp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial2tcp_pkg
//  Description : Shared constants and types for the serial2tcp loopback path.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial2tcp_pkg;

    // Stream width used by the serial2tcp bridge (byte stream).
    localparam int unsigned c_data_w = 8;

    // Default loopback FIFO capacity in bytes.
    localparam int unsigned c_depth = 16;

    // One byte on the stream.
    typedef logic [c_data_w-1:0] byte_t;

endpackage : serial2tcp_pkg
`default_nettype wire

// File: rtl/serial2tcp_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : serial2tcp_sync_fifo
//  Description : Single-clock show-ahead FIFO. Pointers carry one extra wrap
//                bit so full and empty are distinguished without a counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial2tcp_sync_fifo
    import serial2tcp_pkg::*;
#(
    parameter int unsigned DEPTH  = c_depth,
    parameter int unsigned DATA_W = c_data_w
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned c_addr_w = $clog2(DEPTH);
    localparam logic [c_addr_w:0] c_ptr_one = {{c_addr_w{1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_addr_w:0] r_wr_ptr;
    logic [c_addr_w:0] r_rd_ptr;

    logic              w_do_wr;
    logic              w_do_rd;

    // Callers are expected to qualify enables, but guard here as well so a
    // stray enable can never corrupt an occupied entry or underflow.
    assign w_do_wr = i_wr_en && !o_full;
    assign w_do_rd = i_rd_en && !o_empty;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                     (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);

    // Show-ahead: head entry is presented combinationally from storage.
    assign o_rd_data = r_mem[r_rd_ptr[c_addr_w-1:0]];

    // Storage write; contents need no reset since unoccupied entries are never shown.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr[c_addr_w-1:0]] <= i_wr_data;
        end
    end

    // Pointer advance on push/pop; both wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
        end
    end

endmodule : serial2tcp_sync_fifo
`default_nettype wire

// File: rtl/serial2tcp_loopback_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : serial2tcp_loopback_fifo
//  Description : Byte-stream loopback. Bytes accepted on the sink stream are
//                echoed on the source stream, in order, through an elastic
//                FIFO. Valid/ready on both sides, no same-cycle bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial2tcp_loopback_fifo
    import serial2tcp_pkg::*;
#(
    parameter int unsigned DEPTH  = c_depth,
    parameter int unsigned DATA_W = c_data_w
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    output logic              source_valid,
    input  logic              source_ready,
    output logic [DATA_W-1:0] source_data,
    input  logic              sink_valid,
    output logic              sink_ready,
    input  logic [DATA_W-1:0] sink_data
);

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_rd_data;

    // While reset is asserted the pointers are held clear, so the enables
    // need no reset term; out of reset they equal the two handshakes.
    assign w_push = sink_valid   && !w_full;
    assign w_pop  = source_ready && !w_empty;

    // Ready never looks at source_ready: no pass-through when full.
    assign sink_ready   = !w_full  && sys_rst_n;
    assign source_valid = !w_empty && sys_rst_n;

    // Drive zero whenever nothing valid is presented, including during reset,
    // so unoccupied storage never leaks onto the bus.
    assign source_data  = source_valid ? w_rd_data : '0;

    serial2tcp_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .i_wr_en   (w_push),
        .i_wr_data (sink_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

endmodule : serial2tcp_loopback_fifo
`default_nettype wire

// File: tb/tb_serial2tcp_loopback_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial2tcp_loopback_fifo
//  Description : Self-checking bench for serial2tcp_loopback_fifo against a
//                queue-based reference model of the byte stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial2tcp_loopback_fifo;

    localparam int unsigned c_depth  = 16;
    localparam int unsigned c_data_w = 8;

    logic                sys_clk;
    logic                sys_rst_n;
    logic                source_valid;
    logic                source_ready;
    logic [c_data_w-1:0] source_data;
    logic                sink_valid;
    logic                sink_ready;
    logic [c_data_w-1:0] sink_data;

    // Reference model: the bytes currently held, head at index 0.
    logic [7:0] q[$];

    int n_tests;
    int n_fail;

    serial2tcp_loopback_fifo #(
        .DEPTH  (c_depth),
        .DATA_W (c_data_w)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .source_valid (source_valid),
        .source_ready (source_ready),
        .source_data  (source_data),
        .sink_valid   (sink_valid),
        .sink_ready   (sink_ready),
        .sink_data    (sink_data)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Drive one cycle of stimulus, advance past the edge and update the model
    // from its own view of occupancy (never from DUT outputs).
    task automatic drive_cycle(input logic sv, input logic [7:0] sd, input logic sr);
        logic acc;
        logic pop;
        sink_valid   = sv;
        sink_data    = sd;
        source_ready = sr;
        @(posedge sys_clk);
        acc = sv && (q.size() < c_depth);
        pop = sr && (q.size() != 0);
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(sd);
        #1;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0; sink_valid = 1'b0; sink_data = '0; source_ready = 1'b0;
        q.delete();
        repeat (2) @(posedge sys_clk);
        #1;
        n_tests++;
        if (source_valid !== 1'b0 || sink_ready !== 1'b0 || source_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b r=%b d=%h want v=0 r=0 d=00",
                     source_valid, sink_ready, source_data);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        n_tests++;
        if (sink_ready !== 1'b1 || source_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got r=%b v=%b want r=1 v=0", sink_ready, source_valid);
        end
    endtask

    task automatic test_streaming();
        int errs = 0;
        for (int i = 0; i < 24; i++) begin
            drive_cycle(1'b1, i[7:0], 1'b1);
            // After the first push every cycle both pops and pushes: one byte held.
            if (source_valid !== 1'b1 || source_data !== i[7:0] || sink_ready !== 1'b1) begin
                errs++;
                $display("FAIL stream_byte%0d: got v=%b d=%h r=%b want v=1 d=%h r=1",
                         i, source_valid, source_data, sink_ready, i[7:0]);
            end
        end
        n_tests++;
        if (errs != 0) n_fail++;
        drive_cycle(1'b0, 8'h00, 1'b1);
        n_tests++;
        if (source_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_drain: got v=%b want v=0", source_valid);
        end
    endtask

    task automatic test_fill_full();
        int errs = 0;
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1'b1, i[7:0], 1'b0);
            if (sink_ready !== (i != 15) || source_data !== 8'h00 || source_valid !== 1'b1) begin
                errs++;
                $display("FAIL fill_step%0d: got r=%b d=%h v=%b want r=%b d=00 v=1",
                         i, sink_ready, source_data, source_valid, (i != 15));
            end
        end
        n_tests++;
        if (errs != 0) n_fail++;
        // Full cycle: offer 0xEE while popping; it must not be taken.
        drive_cycle(1'b1, 8'hEE, 1'b1);
        n_tests++;
        if (sink_ready !== 1'b1 || source_data !== 8'h01) begin
            n_fail++;
            $display("FAIL full_first_pop: got r=%b d=%h want r=1 d=01", sink_ready, source_data);
        end
        errs = 0;
        for (int i = 1; i < 16; i++) begin
            if (source_valid !== 1'b1 || source_data !== i[7:0]) begin
                errs++;
                $display("FAIL full_drain%0d: got v=%b d=%h want v=1 d=%h",
                         i, source_valid, source_data, i[7:0]);
            end
            drive_cycle(1'b0, 8'h00, 1'b1);
        end
        n_tests++;
        if (errs != 0) n_fail++;
        n_tests++;
        if (source_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_empty_after: got v=%b want v=0 (0xEE must not be stored)", source_valid);
        end
    endtask

    task automatic test_empty();
        int errs = 0;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 8'h5A, 1'b1);
            if (source_valid !== 1'b0) begin
                errs++;
                $display("FAIL empty_idle%0d: got v=%b want v=0", i, source_valid);
            end
        end
        n_tests++;
        if (errs != 0) n_fail++;
        drive_cycle(1'b1, 8'hA5, 1'b0);
        n_tests++;
        if (source_valid !== 1'b1 || source_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL empty_push: got v=%b d=%h want v=1 d=a5", source_valid, source_data);
        end
        drive_cycle(1'b0, 8'h00, 1'b1);
        n_tests++;
        if (source_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_pop: got v=%b want v=0", source_valid);
        end
    endtask

    task automatic test_backpressure();
        int          errs = 0;
        logic [7:0]  cnt  = 8'h40;
        logic [7:0]  exp_seq[$];
        logic [7:0]  got_seq[$];
        logic        held_v = 1'b0;
        logic [7:0]  held_d = '0;
        logic        sr;
        for (int i = 0; i < 300; i++) begin
            sr = ($urandom_range(0, 2) == 0);
            if (sink_ready) begin
                exp_seq.push_back(cnt);
            end
            if (source_valid && sr) got_seq.push_back(source_data);
            // Hold check: a byte shown without ready must reappear unchanged.
            if (held_v && (source_valid !== 1'b1 || source_data !== held_d)) begin
                errs++;
                $display("FAIL bp_hold%0d: got v=%b d=%h want v=1 d=%h", i, source_valid, source_data, held_d);
            end
            if (source_valid && (source_data !== q[0])) begin
                errs++;
                $display("FAIL bp_head%0d: got %h want %h", i, source_data, q[0]);
            end
            if (sink_ready !== (q.size() < c_depth)) begin
                errs++;
                $display("FAIL bp_ready%0d: got %b want %b", i, sink_ready, (q.size() < c_depth));
            end
            held_v = source_valid && !sr;
            held_d = source_data;
            drive_cycle(1'b1, cnt, sr);
            if (exp_seq.size() != 0 && exp_seq[exp_seq.size()-1] == cnt) cnt = cnt + 8'd1;
        end
        for (int i = 0; i < 40 && source_valid; i++) begin
            got_seq.push_back(source_data);
            drive_cycle(1'b0, 8'h00, 1'b1);
        end
        n_tests++;
        if (errs != 0) n_fail++;
        n_tests++;
        if (got_seq != exp_seq) begin
            n_fail++;
            $display("FAIL bp_sequence: got %0d bytes want %0d bytes (contents differ)",
                     got_seq.size(), exp_seq.size());
        end
    endtask

    task automatic test_wrap();
        logic [7:0] sent[$];
        logic [7:0] rcvd[$];
        logic [7:0] b;
        int         grp;
        int         timeout = 0;
        while (sent.size() < 40 && timeout < 200) begin
            grp = (40 - sent.size() < 3) ? 40 - sent.size() : 3;
            for (int k = 0; k < grp; k++) begin
                b = 8'($urandom);
                sent.push_back(b);
                drive_cycle(1'b1, b, 1'b0);
            end
            for (int k = 0; k < grp; k++) begin
                if (source_valid === 1'b1) rcvd.push_back(source_data);
                drive_cycle(1'b0, 8'h00, 1'b1);
            end
            timeout++;
        end
        n_tests++;
        if (rcvd != sent) begin
            n_fail++;
            $display("FAIL wrap_order: got %0d bytes want %0d bytes (contents differ)", rcvd.size(), sent.size());
        end
        n_tests++;
        if (source_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_empty: got v=%b want v=0", source_valid);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'(8'h90 + i), 1'b0);
        n_tests++;
        if (source_valid !== 1'b1 || source_data !== 8'h90) begin
            n_fail++;
            $display("FAIL rstmid_loaded: got v=%b d=%h want v=1 d=90", source_valid, source_data);
        end
        sink_valid = 1'b0;
        #2;
        sys_rst_n = 1'b0;
        q.delete();
        #1;
        n_tests++;
        if (source_valid !== 1'b0 || sink_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_immediate: got v=%b r=%b want v=0 r=0", source_valid, sink_ready);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        n_tests++;
        if (source_valid !== 1'b0 || sink_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_released: got v=%b r=%b want v=0 r=1", source_valid, sink_ready);
        end
        drive_cycle(1'b1, 8'h3C, 1'b0);
        n_tests++;
        if (source_valid !== 1'b1 || source_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL rstmid_first: got v=%b d=%h want v=1 d=3c", source_valid, source_data);
        end
        drive_cycle(1'b0, 8'h00, 1'b1);
        n_tests++;
        if (source_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_single: got v=%b want v=0", source_valid);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_streaming();
        test_fill_full();
        test_empty();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case a stimulus loop is ever broken.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_serial2tcp_loopback_fifo
`default_nettype wire
